// File: rtl/program_loader.sv
// Boot loader: assembles a big-endian byte stream into 16-bit words,
// writes program memory, holds the core in reset until the image is in.
//
// Ports:
//   clk, reset_n         clock, async active-low reset
//   byte_in/_valid/_ready host byte stream (valid/ready)
//   restart              sync abort, start a new load
//   mem_wr_en/_addr/_data program memory write port
//   proc_reset           held high while loading / on error
//   done, err            image loaded / image rejected
module program_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              restart,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              proc_reset,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    DATA_HI,
    DATA_LO,
    DONE_S,
    ERROR_S
  } state_t;

  state_t            state, state_d;
  logic [15:0]       count, count_d;
  logic [ADDR_W:0]   index, index_d;
  logic [7:0]        hi, hi_d;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;
  logic              prst_d, done_d, err_d;

  logic              busy;
  logic              xfer;
  logic [15:0]       n_full;
  logic [16:0]       idx_inc;

  assign busy = (state == CNT_HI) || (state == CNT_LO) ||
                (state == DATA_HI) || (state == DATA_LO);

  assign byte_ready = busy & ~restart & reset_n;
  assign xfer       = byte_valid & byte_ready;
  assign n_full     = {count[15:8], byte_in};
  assign idx_inc    = 17'(index) + 17'd1;

  always_comb begin
    state_d   = state;
    count_d   = count;
    index_d   = index;
    hi_d      = hi;
    wr_en_d   = 1'b0;
    wr_addr_d = mem_wr_addr;
    wr_data_d = mem_wr_data;
    prst_d    = proc_reset;
    done_d    = done;
    err_d     = err;
    if (restart) begin
      state_d = CNT_HI;
      prst_d  = 1'b1;
      done_d  = 1'b0;
      err_d   = 1'b0;
      index_d = '0;
    end else begin
      unique case (state)
        CNT_HI: begin
          if (xfer) begin
            count_d = {byte_in, count[7:0]};
            state_d = CNT_LO;
          end
        end
        CNT_LO: begin
          if (xfer) begin
            count_d = n_full;
            if (n_full == 16'd0) begin
              state_d = DONE_S;
            end else if ({1'b0, n_full} > 17'(DEPTH)) begin
              state_d = ERROR_S;
              err_d   = 1'b1;
            end else begin
              state_d = DATA_HI;
              index_d = '0;
            end
          end
        end
        DATA_HI: begin
          if (xfer) begin
            hi_d    = byte_in;
            state_d = DATA_LO;
          end
        end
        DATA_LO: begin
          if (xfer) begin
            wr_en_d   = 1'b1;
            wr_addr_d = index[ADDR_W-1:0];
            wr_data_d = DATA_W'({hi, byte_in});
            index_d   = index + (ADDR_W+1)'(1);
            // Index is one bit wider than the address so N == DEPTH
            // terminates without wrapping.
            if (idx_inc == {1'b0, count}) state_d = DONE_S;
            else                          state_d = DATA_HI;
          end
        end
        DONE_S: begin
          prst_d = 1'b0;
          done_d = 1'b1;
        end
        ERROR_S: begin
          prst_d = 1'b1;
          err_d  = 1'b1;
        end
        default: state_d = CNT_HI;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= CNT_HI;
      count       <= '0;
      index       <= '0;
      hi          <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      proc_reset  <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_d;
      count       <= count_d;
      index       <= index_d;
      hi          <= hi_d;
      mem_wr_en   <= wr_en_d;
      mem_wr_addr <= wr_addr_d;
      mem_wr_data <= wr_data_d;
      proc_reset  <= prst_d;
      done        <= done_d;
      err         <= err_d;
    end
  end

endmodule
